// File: rtl/program_sequencer_pkg.sv
// Shared definitions for the program sequencer: the FSM state encoding and
// the program-counter width.
package program_sequencer_pkg;

    localparam int PC_W = 10;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        LDWAIT = 2'd2,
        DONE   = 2'd3
    } seq_state_t;

    function automatic logic [PC_W-1:0] pc_inc(input logic [PC_W-1:0] pc);
        return pc + PC_W'(1);
    endfunction

endpackage

// File: rtl/program_sequencer_pc_save.sv
// Three PC save registers, written one at a time by select code 1..3.
// Writes land on the next clock edge; reads are combinational; no backpressure.
module pc_save_regs
    import program_sequencer_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic [1:0]      sel,
    input  logic            wr_en,
    input  logic [PC_W-1:0] wr_dat,
    output logic [PC_W-1:0] rd1,
    output logic [PC_W-1:0] rd2,
    output logic [PC_W-1:0] rd3
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd1 <= '0;
            rd2 <= '0;
            rd3 <= '0;
        end else if (wr_en) begin
            case (sel)
                2'd1:    rd1 <= wr_dat;
                2'd2:    rd2 <= wr_dat;
                2'd3:    rd3 <= wr_dat;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/program_sequencer.sv
// Program sequencer: instruction address generation with loads, jumps and PC saves;
// ProgCtr updates one edge after inputs, Stall is combinational; optional CYCLE_COUNT_EN.
module program_sequencer
    import program_sequencer_pkg::*;
(
    input  logic            Clk,
    input  logic            Reset,
    input  logic            Start,
    input  logic [PC_W-1:0] StartAddr,
    input  logic            JumpEqual,
    input  logic            JumpNotEqual,
    input  logic            OffsetEn,
    input  logic [1:0]      PCRegSelect,
    input  logic            Zero,
    input  logic            LoadInst,
    input  logic            Ack,
    input  logic [7:0]      SaveOffset,
    output logic [PC_W-1:0] ProgCtr,
    output logic            Stall,
    output logic            Busy,
    output logic            Done
`ifdef CYCLE_COUNT_EN
    ,
    output logic [15:0]     CycleCount
`endif
);

    seq_state_t      state, state_nxt;
    logic [PC_W-1:0] pc_nxt;
    logic            save_we;
    logic [PC_W-1:0] save_dat;
    logic [PC_W-1:0] rd1, rd2, rd3;
    logic [PC_W-1:0] sel_pc;
    logic            sel_any;
    logic            jump_taken;
    logic            is_spc;
    logic            start_acc;

    assign sel_any    = (PCRegSelect != 2'b00);
    assign jump_taken = sel_any && ((JumpEqual && Zero) || (JumpNotEqual && !Zero));
    assign is_spc     = sel_any && !JumpEqual && !JumpNotEqual;
    assign save_dat   = pc_inc(ProgCtr) + (OffsetEn ? PC_W'(SaveOffset) : '0);
    assign start_acc  = ((state == IDLE) || (state == DONE)) && Start;

    always_comb begin
        sel_pc = ProgCtr;
        case (PCRegSelect)
            2'd1:    sel_pc = rd1;
            2'd2:    sel_pc = rd2;
            2'd3:    sel_pc = rd3;
            default: sel_pc = ProgCtr;
        endcase
    end

    pc_save_regs u_save (
        .clk    (Clk),
        .rst_n  (Reset),
        .sel    (PCRegSelect),
        .wr_en  (save_we),
        .wr_dat (save_dat),
        .rd1    (rd1),
        .rd2    (rd2),
        .rd3    (rd3)
    );

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state   <= IDLE;
            ProgCtr <= '0;
        end else begin
            state   <= state_nxt;
            ProgCtr <= pc_nxt;
        end
    end

    // Ack outranks LoadInst, so an ending load does not stall
    always_comb begin
        state_nxt = state;
        pc_nxt    = ProgCtr;
        save_we   = 1'b0;
        Stall     = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (Start) begin
                    pc_nxt    = StartAddr;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (Ack) begin
                    state_nxt = DONE;
                end else if (LoadInst) begin
                    Stall     = 1'b1;
                    state_nxt = LDWAIT;
                end else if (jump_taken) begin
                    pc_nxt = sel_pc;
                end else begin
                    save_we = is_spc;
                    pc_nxt  = pc_inc(ProgCtr);
                end
            end
            LDWAIT: begin
                pc_nxt    = pc_inc(ProgCtr);
                state_nxt = RUN;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign Busy = (state == RUN) || (state == LDWAIT);
    assign Done = (state == DONE);

`ifdef CYCLE_COUNT_EN
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            CycleCount <= '0;
        end else if (start_acc) begin
            CycleCount <= '0;
        end else if (Busy && (CycleCount != 16'hFFFF)) begin
            CycleCount <= CycleCount + 16'd1;
        end
    end
`endif

endmodule

// File: doc/program_sequencer.md
PROGRAM_SEQUENCER -- requirements
Module: program_sequencer

Interface
REQ-001 SHALL have these ports, clock and reset first:
- Clk  in  1  sole clock; all state updates on the rising edge.
- Reset  in  1  asynchronous, active-low; 0 = reset asserted.
- Start  in  1  request to begin a program run.
- StartAddr  in  10  first instruction address of the run.
- JumpEqual  in  1  decoded je.
- JumpNotEqual  in  1  decoded jne.
- OffsetEn  in  1  spc adds SaveOffset.
- PCRegSelect  in  2  00 none; 01/10/11 select PC save register 1/2/3.
- Zero  in  1  ALU zero flag.
- LoadInst  in  1  current instruction is a load.
- Ack  in  1  decoded end-of-program.
- SaveOffset  in  8  offset operand for spc.
- ProgCtr  out  10  instruction ROM address.
- Stall  out  1  hold register-file write this cycle.
- Busy  out  1  run in progress.
- Done  out  1  run finished.

Function
REQ-002 SHALL implement the states IDLE, RUN, LDWAIT and DONE.
REQ-003 In IDLE or DONE, Start=1 SHALL load ProgCtr=StartAddr, clear Done and enter RUN on the next edge.
REQ-004 Start in RUN or LDWAIT SHALL be ignored.
REQ-005 In RUN, each cycle SHALL resolve by priority: Ack > LoadInst > taken jump > spc > increment.
REQ-006 Ack=1 in RUN SHALL enter DONE with ProgCtr held.
REQ-007 LoadInst=1 in RUN SHALL assert Stall combinationally that cycle, hold ProgCtr and enter LDWAIT.
REQ-008 LDWAIT SHALL last exactly one cycle with Stall=0, then set ProgCtr=ProgCtr+1 and return to RUN.
REQ-009 A jump SHALL be taken when PCRegSelect!=00 and ((JumpEqual&Zero)|(JumpNotEqual&~Zero)); it SHALL set ProgCtr=PCreg[PCRegSelect].
REQ-010 An untaken je/jne, or any jump with PCRegSelect=00, SHALL set ProgCtr=ProgCtr+1.
REQ-011 spc is PCRegSelect!=00 with neither jump flag set. It SHALL write PCreg[sel]=ProgCtr+1+(OffsetEn ? zero-extended SaveOffset : 0) modulo 2^10, and set ProgCtr=ProgCtr+1.
REQ-012 All PC arithmetic SHALL wrap modulo 2^10 (0x3FF+1=0x000).
REQ-013 Busy SHALL be 1 exactly in RUN and LDWAIT.
REQ-014 Done SHALL be 1 exactly in DONE.
REQ-015 Stall SHALL be 0 outside RUN.
REQ-016 PC save registers SHALL persist across runs and be cleared only by reset.

Reset
REQ-017 Reset=0 SHALL immediately force IDLE, ProgCtr=0, PCreg1..3=0, Busy=0, Done=0 and Stall=0, including mid-run or in LDWAIT.
REQ-018 On the first edge after reset release, the block SHALL behave as IDLE.

Configuration
REQ-019 With CYCLE_COUNT_EN defined, the block SHALL add output CycleCount (16 bits). CycleCount SHALL clear to 0 on reset and on an accepted Start, increment each cycle in RUN or LDWAIT, saturate at 0xFFFF and hold in DONE.
REQ-020 Without CYCLE_COUNT_EN, CycleCount and its counter SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-021 The shared definitions package SHALL hold the seq_state_t enum (IDLE, RUN, LDWAIT, DONE) and the PC width constant (10).
REQ-022 The three PC save registers SHALL be a sub-module pc_save_regs: select, write enable, write data, and three read values.
REQ-023 FSM and ProgCtr logic SHALL remain in program_sequencer.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- Reset release, then Start=1 with StartAddr=0x010 -> ProgCtr=0x010, Busy=1; it then increments 0x011, 0x012 with no jump inputs.
- spc with sel=01, OffsetEn=1, SaveOffset=0x05 at ProgCtr=0x020 -> PCreg1=0x026. A later je sel=01 with Zero=1 -> ProgCtr=0x026; with Zero=0 -> ProgCtr+1.
- LoadInst=1 at ProgCtr=0x030 -> Stall=1 that cycle, ProgCtr=0x030 in LDWAIT, then 0x031 in RUN.
- Ack=1 together with LoadInst=1 -> DONE, Done=1, Busy=0, ProgCtr held. Start again with 0x000 -> RUN from 0x000, PCreg1 retained.
- ProgCtr=0x3FF increment -> 0x000. Reset=0 asserted in LDWAIT -> IDLE, all outputs 0 without waiting for a clock edge.
- With CYCLE_COUNT_EN: a 5-cycle run including one load -> CycleCount=5 in DONE, and it clears on the next Start.
